uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter (50 MHz, 115200 baud byte serializer with `DV`/`Active`/`Done` handshake) among `NUM_REQ` on-chip byte sources. Sources include the debug console, sensor streamer and command responder. The grant is locked for a whole packet, delimited by a per-requester `last` flag, so packets never interleave on the serial line. A watchdog releases the line if a requester stalls or the transmitter never reports done.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter
// The grant is held from the first byte of a packet to its last; a watchdog frees a stalled owner.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 8680
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_byte,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Active,
   input  logic                 i_TX_Done,
   output logic                 o_timeout
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

   state_t               state, state_nxt;
   logic [PW-1:0]        ptr, ptr_nxt;
   logic [PW-1:0]        gidx, gidx_nxt;
   logic [NUM_REQ-1:0]   grant_nxt;
   logic                 tx_dv_nxt;
   logic [7:0]           tx_byte_nxt;
   logic                 last_r, last_nxt;
   logic                 timeout_nxt;
   logic [CW-1:0]        wdog, wdog_nxt;
   logic                 expired;

   logic [PW-1:0]        pick;
   logic [PW-1:0]        idx;
   logic                 pick_ok;
   logic                 sel_valid;
   logic                 sel_last;
   logic [7:0]           sel_byte;

   // First valid requester after the last owner, wrapping around.
   always_comb begin
      pick    = '0;
      idx     = '0;
      pick_ok = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!pick_ok && i_req_valid[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_byte  = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gidx == PW'(k)) begin
            sel_valid = i_req_valid[k];
            sel_last  = i_req_last[k];
            sel_byte  = i_req_byte[8*k +: 8];
         end
      end
   end

   assign expired     = (wdog == CW'(TIMEOUT_CYCLES - 1));
   assign o_req_ready = (state == LOAD) ? o_grant : '0;

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      gidx_nxt    = gidx;
      grant_nxt   = o_grant;
      tx_dv_nxt   = 1'b0;
      tx_byte_nxt = o_TX_Byte;
      last_nxt    = last_r;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok && !i_TX_Active) begin
               gidx_nxt  = pick;
               grant_nxt = NUM_REQ'(1) << pick;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (sel_valid) begin
               tx_byte_nxt = sel_byte;
               last_nxt    = sel_last;
               tx_dv_nxt   = 1'b1;
               state_nxt   = WAIT_DONE;
            end else if (expired) begin
               timeout_nxt = 1'b1;
               ptr_nxt     = gidx;
               grant_nxt   = '0;
               state_nxt   = IDLE;
            end
         end
         WAIT_DONE: begin
            // A done arriving on the expiry cycle wins over the watchdog.
            if (i_TX_Done) begin
               if (last_r) begin
                  ptr_nxt   = gidx;
                  grant_nxt = '0;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = LOAD;
               end
            end else if (expired) begin
               timeout_nxt = 1'b1;
               ptr_nxt     = gidx;
               grant_nxt   = '0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wdog_nxt = ((state_nxt != state) || (state == IDLE)) ? '0 : wdog + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= PW'(NUM_REQ - 1);
         gidx      <= '0;
         o_grant   <= '0;
         o_TX_DV   <= 1'b0;
         o_TX_Byte <= 8'h00;
         last_r    <= 1'b0;
         o_timeout <= 1'b0;
         wdog      <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gidx      <= gidx_nxt;
         o_grant   <= grant_nxt;
         o_TX_DV   <= tx_dv_nxt;
         o_TX_Byte <= tx_byte_nxt;
         last_r    <= last_nxt;
         o_timeout <= timeout_nxt;
         wdog      <= wdog_nxt;
      end
   end

endmodule
